// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, next-PC selection, synchronous instruction memory
// and a single-clock program-load FSM that holds the core while memory is rewritten.
`default_nettype none

module ifetch_unit #(
  parameter int             XLEN      = 32,
  parameter int             DEPTH     = 16384,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     stall,
  input  logic                     branch,
  input  logic                     jump,
  input  logic                     jalr,
  input  logic [XLEN-1:0]          imm32,
  input  logic [XLEN-1:0]          alu_result,
  input  logic                     upg_en,
  input  logic                     upg_wen,
  input  logic [$clog2(DEPTH)-1:0] upg_adr,
  input  logic [31:0]              upg_dat,
  input  logic                     upg_done,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          pc4,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic                     misalign,
  output logic [XLEN-1:0]          bad_addr,
  output logic                     range_err,
  output logic [31:0]              fetch_cnt
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]      mem [DEPTH];
  logic             redirect;
  logic             trap;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  next_pc;
  logic [XLEN-3:0]  fetch_word;
  logic [AW-1:0]    fetch_idx;
  logic             fetch_oor;
  logic [31:0]      fetch_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (upg_en) state_nx = LOAD;
      LOAD:    if (upg_done) state_nx = BOOT;
      default: state_nx = BOOT;
    endcase
  end

  // ---------------- next PC ----------------
  // jalr outranks branch/jump, so its target is the one checked for alignment.
  always_comb begin
    redirect = jalr | branch | jump;
    target   = jalr ? (alu_result & BIT0_CLR) : (pc + imm32);
    trap     = redirect && (target[1:0] != 2'b00);
    if (trap)          next_pc = TRAP_VEC;
    else if (redirect) next_pc = target;
    else               next_pc = pc4;
  end

  assign pc4        = pc + XLEN'(4);
  assign fetch_word = (state == BOOT) ? RESET_VEC[XLEN-1:2] : next_pc[XLEN-1:2];
  assign fetch_idx  = fetch_word[AW-1:0];

  generate
    if (XLEN - 2 > AW) begin : g_range
      assign fetch_oor = |fetch_word[XLEN-3:AW];
      assign range_err = |pc[XLEN-1:AW+2];
    end else begin : g_no_range
      assign fetch_oor = 1'b0;
      assign range_err = 1'b0;
    end
  endgenerate

  assign fetch_data = fetch_oor ? NOP : mem[fetch_idx];

  // ---------------- memory write (load mode only) ----------------
  always_ff @(posedge clk) begin
    if (rstn && (state == LOAD) && upg_wen)
      mem[upg_adr] <= upg_dat;
  end

  // ---------------- PC / fetch registers ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc         <= RESET_VEC;
      inst       <= NOP;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      bad_addr   <= '0;
      fetch_cnt  <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: begin
          pc         <= RESET_VEC;
          inst       <= fetch_data;
          inst_valid <= 1'b1;
        end
        RUN: begin
          if (upg_en) begin
            inst_valid <= 1'b0;
            inst       <= NOP;
          end else if (!stall) begin
            pc        <= next_pc;
            inst      <= fetch_data;
            fetch_cnt <= fetch_cnt + 32'd1;
            if (trap) begin
              misalign <= 1'b1;
              bad_addr <= target;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: per-cycle behavioural model plus directed literal checks.
`default_nettype none

module tb_ifetch_unit;
  localparam int          DEPTH = 128;
  localparam logic [31:0] TRAP  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rstn, stall, branch, jump, jalr;
  logic [31:0] imm32, alu_result;
  logic        upg_en, upg_wen, upg_done;
  logic [6:0]  upg_adr;
  logic [31:0] upg_dat;
  logic [31:0] pc, pc4, inst, bad_addr, fetch_cnt;
  logic        inst_valid, misalign, range_err;

  ifetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VEC(32'h0), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .branch(branch), .jump(jump), .jalr(jalr),
    .imm32(imm32), .alu_result(alu_result), .upg_en(upg_en), .upg_wen(upg_wen),
    .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_done(upg_done), .pc(pc), .pc4(pc4),
    .inst(inst), .inst_valid(inst_valid), .misalign(misalign), .bad_addr(bad_addr),
    .range_err(range_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;   // 0 boot, 1 run, 2 load
  logic [31:0] m_pc, m_inst, m_bad, m_cnt;
  bit          m_valid, m_mis, m_ik, m_live;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  initial begin
    m_live = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
  end

  function automatic void mfetch(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (w >= DEPTH) begin
      m_inst = NOP; m_ik = 1;
    end else begin
      m_inst = m_mem[w]; m_ik = m_known[w];
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] t, npc;
    bit redir;
    if (!rstn) begin
      m_mode = 0; m_pc = 0; m_inst = NOP; m_ik = 1;
      m_valid = 0; m_mis = 0; m_bad = 0; m_cnt = 0; m_live = 1;
    end else if (m_live) begin
      m_mis = 0;
      if (m_mode == 0) begin
        m_pc = 0; mfetch(0); m_valid = 1; m_mode = 1;
      end else if (m_mode == 1) begin
        if (upg_en) begin
          m_mode = 2; m_valid = 0; m_inst = NOP; m_ik = 1;
        end else if (!stall) begin
          redir = jalr || branch || jump;
          t = jalr ? {alu_result[31:1], 1'b0} : m_pc + imm32;
          if (redir && (t % 4 != 0)) begin
            npc = TRAP; m_bad = t; m_mis = 1;
          end else if (redir) npc = t;
          else npc = m_pc + 4;
          m_pc = npc; mfetch(npc); m_cnt = m_cnt + 1;
        end
      end else begin
        if (upg_wen) begin
          m_mem[upg_adr] = upg_dat; m_known[upg_adr] = 1;
        end
        if (upg_done) m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 32'd4);
      if (m_ik) chk("inst", inst, m_inst);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("bad_addr", bad_addr, m_bad);
      chk("range_err", {31'd0, range_err}, ((m_pc >> 2) >= DEPTH) ? 32'd1 : 32'd0);
      chk("fetch_cnt", fetch_cnt, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branch = 0; jump = 0; jalr = 0; stall = 0; imm32 = 0; alu_result = 0;
    upg_en = 0; upg_wen = 0; upg_done = 0; upg_adr = 0; upg_dat = 0;
  endtask

  initial begin
    rstn = 0; clr();
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    rstn = 1;
    tick();
    chk("boot_valid", {31'd0, inst_valid}, 32'd1);

    // fill memory with C0DE_0000 + word index
    upg_en = 1; tick();
    upg_en = 0;
    for (int i = 0; i < DEPTH; i++) begin
      upg_wen = 1; upg_adr = 7'(i); upg_dat = 32'hC0DE_0000 + i; upg_done = (i == DEPTH - 1);
      tick();
      chk("load_valid", {31'd0, inst_valid}, 32'd0);
    end
    clr(); tick();
    chk("run0_pc", pc, 32'h0);
    chk("run0_inst", inst, 32'hC0DE_0000);
    tick(); tick(); tick();
    chk("seq_pc", pc, 32'hC);
    chk("seq_cnt", fetch_cnt, 32'd3);
    chk("seq_inst", inst, 32'hC0DE_0003);
    tick();
    branch = 1; imm32 = 32'hFFFF_FFF8; tick(); clr();
    chk("br_pc", pc, 32'h8);
    chk("br_inst", inst, 32'hC0DE_0002);
    jalr = 1; alu_result = 32'h41; tick(); clr();
    chk("jalr_pc", pc, 32'h40);
    branch = 1; jump = 1; jalr = 1; imm32 = 32'h8; alu_result = 32'h61; tick(); clr();
    chk("prio_pc", pc, 32'h60);
    chk("prio_inst", inst, 32'hC0DE_0018);
    jalr = 1; alu_result = 32'h20; tick(); clr();
    jump = 1; imm32 = 32'h6; tick(); clr();
    chk("trap_pc", pc, TRAP);
    chk("trap_bad", bad_addr, 32'h26);
    chk("trap_mis", {31'd0, misalign}, 32'd1);
    tick();
    chk("trap_mis_clr", {31'd0, misalign}, 32'd0);
    jalr = 1; alu_result = 32'h43; tick(); clr();
    chk("jtrap_pc", pc, TRAP);
    chk("jtrap_bad", bad_addr, 32'h42);
    tick();
    chk("pre_stall_pc", pc, 32'h104);
    chk("pre_stall_cnt", fetch_cnt, 32'd12);
    stall = 1; branch = 1; imm32 = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", pc, 32'h104);
      chk("stall_cnt", fetch_cnt, 32'd12);
      chk("stall_inst", inst, 32'hC0DE_0041);
    end
    clr(); tick();
    chk("unstall_pc", pc, 32'h108);
    jump = 1; imm32 = 32'hF8; tick(); clr();
    chk("oor_pc", pc, 32'h200);
    chk("oor_err", {31'd0, range_err}, 32'd1);
    chk("oor_inst", inst, NOP);
    tick();
    jalr = 1; alu_result = 32'h1FC; tick(); clr();
    chk("edge_inst", inst, 32'hC0DE_007F);
    chk("edge_err", {31'd0, range_err}, 32'd0);
    jalr = 1; alu_result = 32'hFFFF_FFFC; tick(); clr();
    chk("wrap_pc4", pc4, 32'h0);

    // program load while stalled
    upg_en = 1; stall = 1; tick(); clr();
    chk("ld_valid", {31'd0, inst_valid}, 32'd0);
    upg_wen = 1; upg_adr = 7'd0; upg_dat = 32'hDEAD_BEEF; tick();
    upg_adr = 7'd1; upg_dat = 32'h0050_0093; upg_done = 1; tick(); clr();
    chk("ld_valid2", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("ld_pc0", pc, 32'h0);
    chk("ld_inst0", inst, 32'hDEAD_BEEF);
    tick();
    chk("ld_inst1", inst, 32'h0050_0093);

    // reset during load
    upg_en = 1; tick(); clr();
    upg_wen = 1; upg_adr = 7'd2; upg_dat = 32'h1234_5678; tick();
    rstn = 0; upg_adr = 7'd3; upg_dat = 32'h0000_0BAD; tick(); clr();
    rstn = 1;
    chk("abort_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("abort_boot_valid", {31'd0, inst_valid}, 32'd1);
    chk("abort_inst", inst, 32'hDEAD_BEEF);
    jalr = 1; alu_result = 32'h8; tick(); clr();
    chk("kept_word", inst, 32'h1234_5678);
    jalr = 1; alu_result = 32'hC; tick(); clr();
    chk("unwritten_word", inst, 32'hC0DE_0003);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction-fetch stage for the single-cycle RISC-V core. It holds the PC, selects the next PC from sequential, branch/jump, and jalr paths, and fetches from an internal synchronous instruction memory. Beyond the first-generation fetch block, it adds:
- configurable width, depth, and reset/trap vectors;
- a stall input;
- misaligned-target trapping;
- out-of-range detection;
- a fetch counter;
- a single-clock program-load (UART upgrade) FSM that holds the core while memory is rewritten.

## Interface
- XLEN, 32, datapath/PC width
- DEPTH, 16384, instruction memory depth in 32-bit words (power of two); AW = $clog2(DEPTH)
- RESET_VEC, 0, PC after reset and after program load
- TRAP_VEC, 32'h0000_0100, PC after a misaligned-target trap
- clk  in  1  only clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- stall  in  1  hold PC, inst, and counter
- branch  in  1  taken conditional branch; target = pc + imm32
- jump  in  1  jal; target = pc + imm32
- jalr  in  1  target = {alu_result[XLEN-1:1], 1'b0}
- imm32  in  XLEN  branch/jal offset (sign-extended)
- alu_result  in  XLEN  jalr target sum
- upg_en  in  1  request program-load mode
- upg_wen  in  1  write strobe in load mode
- upg_adr  in  AW  word address
- upg_dat  in  32  word data
- upg_done  in  1  load finished
- pc  out  XLEN  address of inst
- pc4  out  XLEN  pc + 4, modulo 2^XLEN
- inst  out  32  fetched instruction
- inst_valid  out  1  inst is executable this cycle
- misalign  out  1  one-cycle pulse, trap taken
- bad_addr  out  XLEN  last misaligned target
- range_err  out  1  pc word index ≥ DEPTH
- fetch_cnt  out  32  count of valid, unstalled fetches (wraps)

## Operation
- FSM states: BOOT, RUN, LOAD.
- Reset (rstn=0 at an edge):
  - state←BOOT, pc←RESET_VEC, inst←32'h0000_0013 (NOP).
  - inst_valid←0, misalign←0, bad_addr←0, fetch_cnt←0.
  - Memory contents are not cleared.
- BOOT: after one cycle, state←RUN; pc←RESET_VEC; inst←mem[RESET_VEC index]; inst_valid←1.
- RUN, stall=0, next-PC priority (highest first):
  1. Misaligned target. A jalr target has bit1 set, or a branch/jump target has bits[1:0]≠0.
     - pc←TRAP_VEC, bad_addr←offending target, misalign←1 for one cycle.
  2. jalr → cleared jalr target.
  3. branch|jump → pc+imm32.
  4. Otherwise pc+4.
- In RUN with stall=0, every edge also:
  - fetches inst←mem[next_pc index]; pc and inst therefore always correspond;
  - increments fetch_cnt.
- RUN, stall=1: pc, inst, and fetch_cnt hold; redirect inputs are ignored.
- RUN, upg_en=1 (regardless of stall):
  - state←LOAD, inst_valid←0, inst←NOP, pc holds.
- LOAD:
  - upg_wen=1 with upg_adr<DEPTH → mem[upg_adr]←upg_dat.
  - Core-side inputs are ignored.
  - upg_done=1 → state←BOOT. A simultaneous upg_wen write is still performed.
- Out-of-range fetch (index ≥ DEPTH, only reachable if XLEN-2 > AW): inst←NOP, range_err=1 while that pc is held.
- Word index = pc[AW+1:2]. Upper bits are checked for range_err only.

## Timing
- Next-PC and fetch are registered together: zero-bubble sequential and redirected fetch.
- Latency from a redirect input (sampled at edge N) to the new pc/inst: visible after edge N.
- Reset to first valid instruction: the edge after rstn deasserts gives BOOT→RUN, so inst_valid is high from 1 cycle after release.
- Load entry: inst_valid drops the cycle after upg_en is sampled.
- Load exit: upg_done sampled at edge N → BOOT; edge N+1 → inst_valid=1 with mem[RESET_VEC].
- Reset mid-LOAD aborts the load: state←BOOT, and words already written remain.
- pc4 and range_err are combinational from pc.
- Memory is single-port, written only in LOAD, so there is no read/write collision.

## Test plan
- Reset then run: pc=0, inst=mem[0], and inst_valid rises 1 cycle after release. After 3 edges, pc=0xC and fetch_cnt=3.
- Branch and jalr redirects:
  - branch=1, imm32=-8 at pc=0x10 → pc=0x8 next cycle.
  - jalr=1, alu_result=0x41 → pc=0x40.
  - branch, jump, and jalr all high → jalr target wins.
- Misalignment trap: jump=1, imm32=0x6 at pc=0x20.
  - pc=TRAP_VEC, bad_addr=0x26, misalign high exactly 1 cycle.
  - jalr to 0x43 (bit1 set after clearing bit0) → same trap.
- Stall: stall held 4 cycles with branch=1.
  - pc, inst, and fetch_cnt are unchanged and the branch is not taken.
  - On release, pc advances by 4.
- Program load: upg_en=1, then write 0xDEADBEEF to addr 0 and 0x00500093 to addr 1, with upg_done in the same cycle as the last write.
  - inst_valid=0 throughout the load.
  - After BOOT, inst=0xDEADBEEF at pc=0, then 0x00500093 at pc=4.
- Reset mid-load: rstn pulsed low after 1 of 2 writes.
  - FSM goes to BOOT then RUN, the word already written persists, and inst_valid rises 1 cycle after release.
